// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit core.
// Byte-serial fetch, operand-source enables, PC/stack and writeback control.
module instr_sequencer #(
  parameter int         RAM_LAT = 2,
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [7:0] progAddr,
  output logic       progReq,
  input  logic       progAck,
  input  logic [7:0] progData,
  output logic [7:0] opcode1,
  output logic [7:0] opcode2,
  output logic [7:0] opcode3,
  output logic [7:0] opcode4,
  output logic       imm1,
  output logic       imm2,
  output logic       counterEnable1,
  output logic       counterEnable2,
  output logic       inputEnable1,
  output logic       inputEnable2,
  output logic       ramEnable1,
  output logic       ramEnable2,
  output logic       stackEnable1,
  output logic       stackEnable2,
  input  logic       condition,
  input  logic [7:0] stackTop,
  output logic       stackPush,
  output logic       stackPop,
  output logic [7:0] pushData,
  output logic [7:0] pc,
  output logic       regWrite,
  output logic [7:0] regDest,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_COMMIT, S_HALT
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(RAM_LAT - 1);

  state_t     state, nstate;
  logic [1:0] k;
  logic [7:0] ecnt;
  logic       cond_q;
  logic [3:0] src1, src2;
  logic       slow, last_exec;
  logic       is_cond, is_call, is_ret;
  logic [7:0] npc;

  // {counter, input, ram, stack}; immediates never select a source
  function automatic logic [3:0] src_dec(input logic imm, input logic [7:0] c);
    src_dec = 4'b0000;
    if (!imm) begin
      unique case (c)
        8'h06:   src_dec = 4'b1000;
        8'h07:   src_dec = 4'b0100;
        8'h08:   src_dec = 4'b0010;
        8'h09:   src_dec = 4'b0001;
        default: src_dec = 4'b0000;
      endcase
    end
  endfunction

  assign src1      = src_dec(opcode1[7], opcode2);
  assign src2      = src_dec(opcode1[6], opcode3);
  assign slow      = |{src1[1:0], src2[1:0]};
  assign last_exec = (ecnt == (slow ? LAT_M1 : 8'd0));
  assign is_cond   = opcode1[5];
  assign is_call   = (opcode1[4:3] == 2'b01);
  assign is_ret    = (opcode1[4:3] == 2'b10);
  assign progAddr  = pc + {6'b0, k};
  assign pushData  = pc + 8'd4;
  assign regDest   = opcode4;

  always_comb begin
    npc = pc + 8'd4;
    if (is_cond && cond_q) npc = is_ret ? stackTop : opcode4;
  end

  always_comb begin
    nstate         = state;
    progReq        = 1'b0;
    imm1           = 1'b0;
    imm2           = 1'b0;
    counterEnable1 = 1'b0;
    counterEnable2 = 1'b0;
    inputEnable1   = 1'b0;
    inputEnable2   = 1'b0;
    ramEnable1     = 1'b0;
    ramEnable2     = 1'b0;
    stackEnable1   = 1'b0;
    stackEnable2   = 1'b0;
    stackPush      = 1'b0;
    stackPop       = 1'b0;
    regWrite       = 1'b0;
    halted         = 1'b0;
    unique case (state)
      S_IDLE: if (run) nstate = S_FETCH;
      S_FETCH: begin
        progReq = 1'b1;
        if (progAck && k == 2'd3) nstate = S_DECODE;
      end
      S_DECODE: nstate = (opcode1 == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC: begin
        imm1           = opcode1[7];
        imm2           = opcode1[6];
        counterEnable1 = src1[3];
        inputEnable1   = src1[2];
        ramEnable1     = src1[1];
        stackEnable1   = src1[0];
        counterEnable2 = src2[3];
        inputEnable2   = src2[2];
        ramEnable2     = src2[1];
        stackEnable2   = src2[0];
        if (last_exec) nstate = S_COMMIT;
      end
      S_COMMIT: begin
        nstate = S_FETCH;
        if (!is_cond) begin
          regWrite = 1'b1;
        end else if (cond_q) begin
          stackPush = is_call;
          stackPop  = is_ret;
        end
      end
      S_HALT: halted = 1'b1;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= 8'd0;
      k       <= 2'd0;
      ecnt    <= 8'd0;
      cond_q  <= 1'b0;
      opcode1 <= 8'd0;
      opcode2 <= 8'd0;
      opcode3 <= 8'd0;
      opcode4 <= 8'd0;
    end else begin
      state <= nstate;
      unique case (state)
        S_IDLE: begin
          pc <= 8'd0;
          k  <= 2'd0;
        end
        S_FETCH: begin
          if (progAck) begin
            unique case (k)
              2'd0: opcode1 <= progData;
              2'd1: opcode2 <= progData;
              2'd2: opcode3 <= progData;
              2'd3: opcode4 <= progData;
              default: ;
            endcase
            k <= k + 2'd1;
          end
        end
        S_DECODE: ecnt <= 8'd0;
        S_EXEC: begin
          ecnt <= ecnt + 8'd1;
          if (last_exec) cond_q <= condition;
        end
        S_COMMIT: pc <= npc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed program, queued expected
// events, and an independent monitor that pops and compares.
module tb_instr_sequencer;
  logic       clk = 1'b0;
  logic       rst, run, progAck, condition;
  logic [7:0] progData, stackTop;
  logic [7:0] progAddr, pc, pushData, regDest;
  logic [7:0] opcode1, opcode2, opcode3, opcode4;
  logic       progReq, imm1, imm2, stackPush, stackPop, regWrite, halted;
  logic       counterEnable1, counterEnable2, inputEnable1, inputEnable2;
  logic       ramEnable1, ramEnable2, stackEnable1, stackEnable2;

  typedef struct packed {
    logic [7:0]  kind;
    logic [31:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] mem [256];
  logic       cond_map [256];
  int         cmp_cnt = 0;
  int         mism_cnt = 0;

  always #5 clk = ~clk;

  assign condition = cond_map[pc];
  assign stackTop  = 8'h14;

  instr_sequencer #(.RAM_LAT(2), .HALT_OP(8'hFF)) dut (
    .clk(clk), .rst(rst), .run(run),
    .progAddr(progAddr), .progReq(progReq), .progAck(progAck),
    .progData(progData),
    .opcode1(opcode1), .opcode2(opcode2), .opcode3(opcode3),
    .opcode4(opcode4), .imm1(imm1), .imm2(imm2),
    .counterEnable1(counterEnable1), .counterEnable2(counterEnable2),
    .inputEnable1(inputEnable1), .inputEnable2(inputEnable2),
    .ramEnable1(ramEnable1), .ramEnable2(ramEnable2),
    .stackEnable1(stackEnable1), .stackEnable2(stackEnable2),
    .condition(condition), .stackTop(stackTop),
    .stackPush(stackPush), .stackPop(stackPop), .pushData(pushData),
    .pc(pc), .regWrite(regWrite), .regDest(regDest), .halted(halted)
  );

  task automatic expect_ev(input logic [7:0] kind, input logic [31:0] data);
    exp_q.push_back({kind, data});
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    cmp_cnt++;
    if (act !== want) begin
      mism_cnt++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic got(input logic [7:0] kind, input logic [31:0] data);
    ev_t e;
    cmp_cnt++;
    if (exp_q.size() == 0) begin
      mism_cnt++;
      $display("FAIL ev_extra: got %c/%h with nothing pending", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.data !== data) begin
        mism_cnt++;
        $display("FAIL ev_%c: got %c/%h want %c/%h",
                 e.kind, kind, data, e.kind, e.data);
      end
    end
  endtask

  task automatic wait_empty(input int lim, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge clk);
      #2;
      n++;
    end
    cmp_cnt++;
    if (exp_q.size() != 0) begin
      mism_cnt++;
      $display("FAIL %s_timeout: got %0d pending want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Program memory: ack two cycles into each requested byte
  initial begin
    int wcnt = 0;
    progAck  = 1'b0;
    progData = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      progAck = 1'b0;
      if (progReq && !rst) begin
        wcnt++;
        if (wcnt == 2) begin
          progAck  = 1'b1;
          progData = mem[progAddr];
          wcnt     = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: turns DUT activity into events for the scoreboard
  initial begin
    logic       pending = 1'b0, d_next = 1'b0, rq_prev = 1'b0, h_prev = 1'b0;
    logic [9:0] mask = '0, cur;
    logic [7:0] ecyc = '0;
    int         acks = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0; d_next = 1'b0; rq_prev = 1'b0; h_prev = 1'b0;
        mask = '0; ecyc = '0; acks = 0;
      end else begin
        if (d_next) begin
          got("D", {opcode1, opcode2, opcode3, opcode4});
          d_next = 1'b0;
        end
        if (progReq && progAck) begin
          acks++;
          if (acks == 4) begin
            acks   = 0;
            d_next = 1'b1;
          end
        end
        cur = {imm1, imm2, counterEnable1, counterEnable2,
               inputEnable1, inputEnable2, ramEnable1, ramEnable2,
               stackEnable1, stackEnable2};
        if (cur != '0) begin
          mask |= cur;
          ecyc++;
        end
        if (progReq && !rq_prev) begin
          if (pending) got("X", {14'b0, mask, ecyc});
          pending = 1'b1;
          mask    = '0;
          ecyc    = '0;
          got("F", {24'b0, progAddr});
        end
        if (regWrite)  got("W", {24'b0, regDest});
        if (stackPush) got("P", {24'b0, pushData});
        if (stackPop)  got("O", 32'h0);
        if (halted && !h_prev) got("H", 32'h0);
        rq_prev = progReq;
        h_prev  = halted;
      end
    end
  end

  initial begin
    int reqs;
    logic [7:0] prog [40];
    logic [7:0] addrs [10];
    prog = '{8'h00, 8'h01, 8'h02, 8'h03,
             8'h00, 8'h08, 8'h05, 8'h11,
             8'h80, 8'h08, 8'h05, 8'h12,
             8'h20, 8'h00, 8'h00, 8'h40,
             8'h28, 8'h00, 8'h00, 8'h80,
             8'h20, 8'h00, 8'h00, 8'h90,
             8'h30, 8'h00, 8'h00, 8'h00,
             8'h20, 8'h00, 8'h00, 8'hFC,
             8'h00, 8'h09, 8'h06, 8'h21,
             8'h00, 8'h00, 8'h00, 8'h00};
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
              8'h80, 8'h90, 8'h14, 8'hFC, 8'h00};
    for (int i = 0; i < 256; i++) begin
      mem[i]      = 8'h00;
      cond_map[i] = 1'b0;
    end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 4; j++)
        mem[addrs[i] + 8'(j)] = prog[i*4 + j];
    cond_map[8'h10] = 1'b1;
    cond_map[8'h80] = 1'b1;
    cond_map[8'h90] = 1'b1;
    cond_map[8'h14] = 1'b1;

    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", {24'b0, pc}, 32'h0);
    chk("rst_req", {31'b0, progReq}, 32'h0);
    chk("rst_halt", {31'b0, halted}, 32'h0);
    chk("rst_op1", {24'b0, opcode1}, 32'h0);
    chk("rst_wr", {31'b0, regWrite}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_req", {31'b0, progReq}, 32'h0);

    expect_ev("F", 32'h00); expect_ev("D", 32'h00010203); expect_ev("W", 32'h03);
    expect_ev("X", 32'h0);  expect_ev("F", 32'h04);
    expect_ev("D", 32'h00080511); expect_ev("W", 32'h11);
    expect_ev("X", 32'h0802); expect_ev("F", 32'h08);
    expect_ev("D", 32'h80080512); expect_ev("W", 32'h12);
    expect_ev("X", 32'h20001); expect_ev("F", 32'h0C);
    expect_ev("D", 32'h20000040);
    expect_ev("X", 32'h0);  expect_ev("F", 32'h10);
    expect_ev("D", 32'h28000080); expect_ev("P", 32'h14);
    expect_ev("X", 32'h0);  expect_ev("F", 32'h80);
    expect_ev("D", 32'h20000090);
    expect_ev("X", 32'h0);  expect_ev("F", 32'h90);
    expect_ev("D", 32'h30000000); expect_ev("O", 32'h0);
    expect_ev("X", 32'h0);  expect_ev("F", 32'h14);
    expect_ev("D", 32'h200000FC);
    expect_ev("X", 32'h0);  expect_ev("F", 32'hFC);
    expect_ev("D", 32'h00090621); expect_ev("W", 32'h21);
    expect_ev("X", 32'h4202); expect_ev("F", 32'h00);
    run = 1'b1;
    wait_empty(3000, "prog");

    rst = 1'b1;
    @(negedge clk);
    chk("midfetch_req", {31'b0, progReq}, 32'h0);
    chk("midfetch_pc", {24'b0, pc}, 32'h0);
    chk("midfetch_op4", {24'b0, opcode4}, 32'h0);

    mem[8'h00] = 8'h20; mem[8'h01] = 8'h00;
    mem[8'h02] = 8'h00; mem[8'h03] = 8'hFC;
    mem[8'hFC] = 8'hFF;
    cond_map[8'h00] = 1'b1;
    @(negedge clk);
    expect_ev("F", 32'h00); expect_ev("D", 32'h200000FC);
    expect_ev("X", 32'h0);  expect_ev("F", 32'hFC);
    expect_ev("D", 32'hFF090621); expect_ev("H", 32'h0);
    rst = 1'b0;
    wait_empty(1000, "halt");

    reqs = 0;
    repeat (30) begin
      @(negedge clk);
      if (progReq) reqs++;
    end
    chk("halt_noreq", reqs, 32'h0);
    chk("halt_hold", {31'b0, halted}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("halt_rst", {31'b0, halted}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/execute sequencer for the 8-bit core.
- Fetches each 4-byte instruction byte-serially from program memory over a req/ack handshake, then holds the decoded opcode bytes.
- Drives the operand-mux select enables and immediate flags, waits out RAM/stack read latency, and issues register writeback.
- Owns the program counter, including conditional jump, call (push) and return (pop).

Parameters:
- RAM_LAT, 2, EXEC-state cycles when either operand comes from RAM or stack (min 1).
- HALT_OP, 8'hFF, opcode byte that halts the sequencer.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; leaving IDLE requires run=1.
- progAddr  output  8  program memory byte address.
- progReq  output  1  fetch request; held until progAck.
- progAck  input  1  progData valid this cycle.
- progData  input  8  fetched byte.
- opcode1..opcode4  output  8 each  latched instruction bytes 0..3.
- imm1, imm2  output  1 each  opcode1[7], opcode1[6]; valid in EXEC only, else 0.
- counterEnable1/2, inputEnable1/2, ramEnable1/2, stackEnable1/2  output  1 each  operand source enables; valid in EXEC only.
- condition  input  1  ALU compare result, sampled in the last EXEC cycle.
- stackTop  input  8  stack read data (return address).
- stackPush, stackPop  output  1 each  one-cycle pulses.
- pushData  output  8  return address for stackPush.
- pc  output  8  current instruction address.
- regWrite  output  1  one-cycle writeback strobe.
- regDest  output  8  writeback destination (= opcode4).
- halted  output  1  high in HALT.

Behaviour:
- Decode fields:
  - opcode1[7] = imm1; opcode1[6] = imm2.
  - opcode1[5] = conditional class: opcode4 is a jump target, no writeback.
  - opcode1[4:3]: 00 = normal, 01 = call, 10 = ret.
- Operand source codes (opcode2 when imm1=0, opcode3 when imm2=0):
  - 0x06 = counter, 0x07 = input, 0x08 = ram, 0x09 = stack.
  - Any other code asserts no enable (register file path).
  - When immX=1, no enable is asserted for that operand.
- States:
  - IDLE: pc=0; stay here until run=1 -> FETCH.
  - FETCH: byte counter k=0..3. progAddr = pc+k (mod 256), progReq=1. On progAck, latch progData into opcode(k+1) and increment k. progReq stays high across consecutive bytes. After byte 3 is acked -> DECODE.
  - DECODE: 1 cycle. If opcode1 == HALT_OP -> HALT, else -> EXEC.
  - EXEC: enables driven. Lasts RAM_LAT cycles if any ram/stack enable is asserted, else 1 cycle. -> COMMIT.
  - COMMIT: 1 cycle; performs the PC/stack/writeback action below, then -> FETCH.
  - HALT: halted=1; stays until rst.
- COMMIT actions, by class:
  - Conditional with condition=1: pc <= opcode4.
  - Call with condition=1: pc <= opcode4; stackPush=1; pushData = pc+4.
  - Ret with condition=1: stackPop=1; pc <= stackTop.
  - Non-conditional class: regWrite=1; regDest = opcode4.
  - All other cases: pc <= pc+4.
- All pc arithmetic is mod 256; pc=0xFC advances to 0x00.
- Reset values: state=IDLE, pc=0, k=0, opcode1..4=0. All strobes, enables, progReq and halted = 0.
- Reset mid-fetch drops progReq in the following cycle; a same-cycle progAck is ignored.
- progAck while progReq=0 is ignored.
- Strobes (regWrite, stackPush, stackPop) are never asserted outside COMMIT and are mutually exclusive.

Test Plan:
- Fetch and writeback:
  - Stimulus: rst, run=1; memory holds 00 01 02 03 at addr 0; progAck after a 2-cycle delay per byte.
  - Response: opcode1..4 = 00,01,02,03; regWrite pulse with regDest=0x03; pc=4 on the next FETCH.
- RAM source latency:
  - Stimulus: opcode1=0x00, opcode2=0x08, RAM_LAT=2.
  - Response: ramEnable1 high for exactly 2 cycles; imm1=0.
- Immediate operand:
  - Stimulus: opcode1=0x80, opcode2=0x08.
  - Response: imm1=1, ramEnable1=0, EXEC lasts 1 cycle.
- Taken conditional jump:
  - Stimulus: opcode1=0x20, opcode4=0x40, condition=1.
  - Response: pc=0x40; no regWrite.
  - Repeat with condition=0: pc=pc+4.
- Call then ret:
  - Stimulus: call at pc=0x10 to 0x80; later ret with stackTop=0x14.
  - Response: stackPush with pushData=0x14, pc=0x80; then stackPop, pc=0x14.
- Halt and wrap:
  - Stimulus: opcode1=0xFF at pc=0xFC.
  - Response: halted=1, no further progReq until rst.
  - Stimulus: a normal instruction at 0xFC.
  - Response: pc wraps to 0x00.
